ai_i2s_irq_agg: RTL and testbench

- Parametrised interrupt aggregator for the I2S subsystem; successor to the two-source buffer IRQ controller.
- Collects NUM_SRC event lines (buffer full/empty, FIFO over/underrun, frame errors), one of two capture modes per source.
- Latches per-source status with sticky overflow tracking; applies per-source mask and global enable.
- Drives one registered CPU interrupt plus the index of the lowest pending source. Sits between the I2S datapath and the register file.

---
 rtl/ai_i2s_irq_agg_if.sv | 31 +++
 rtl/ai_i2s_irq_agg.sv | 144 ++++++++++++++
 tb/tb_ai_i2s_irq_agg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ai_i2s_irq_agg_if.sv
// Bus bundle between the I2S interrupt aggregator and its register file / datapath.
// master drives controls and events, slave (the aggregator) returns status and the IRQ.
interface ai_i2s_irq_agg_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int CNT_W   = 8
);
  logic               irq_en;
  logic [NUM_SRC-1:0] irq_mask;
  logic [NUM_SRC-1:0] irq_mode;
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] intclr;
  logic [NUM_SRC-1:0] intset;
  logic [CNT_W-1:0]   coal_thresh;
  logic [CNT_W-1:0]   coal_timeout;
  logic [NUM_SRC-1:0] intstat;
  logic [NUM_SRC-1:0] intovf;
  logic [NUM_SRC-1:0] intpend;
  logic               irq_o;
  logic [ID_W-1:0]    irq_id;

  modport master (
    output irq_en, irq_mask, irq_mode, irq_src, intclr, intset, coal_thresh, coal_timeout,
    input  intstat, intovf, intpend, irq_o, irq_id
  );

  modport slave (
    input  irq_en, irq_mask, irq_mode, irq_src, intclr, intset, coal_thresh, coal_timeout,
    output intstat, intovf, intpend, irq_o, irq_id
  );
endinterface

// File: rtl/ai_i2s_irq_agg.sv
// I2S interrupt aggregator: per-source edge/level capture, sticky overflow, mask, priority id.
// Optional macro AI_I2S_IRQ_COALESCE_EN replaces the direct irq_o path with a coalescing FSM.
module ai_i2s_irq_agg #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ai_i2s_irq_agg_if.slave   bus
);

  logic [NUM_SRC-1:0] r_src_prev;
  logic [NUM_SRC-1:0] r_intstat;
  logic [NUM_SRC-1:0] r_intovf;
  logic [NUM_SRC-1:0] w_evt;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_stat_next;
  logic [NUM_SRC-1:0] w_ovf_next;
  logic [NUM_SRC-1:0] w_pend;
  logic [ID_W-1:0]    w_id;

  assign w_evt = bus.irq_src & ~r_src_prev;
  assign w_set = w_evt | bus.intset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      // A set always beats a coincident clear so no event is lost in edge mode.
      assign w_stat_next[gi] = bus.irq_mode[gi]
        ? (bus.irq_src[gi] | bus.intset[gi] | (r_intstat[gi] & ~bus.intclr[gi]))
        : (w_set[gi] | (r_intstat[gi] & ~bus.intclr[gi]));
      assign w_ovf_next[gi] =
          (~bus.irq_mode[gi] & r_intstat[gi] & w_set[gi] & ~bus.intclr[gi])
        | (r_intovf[gi] & ~bus.intclr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_prev <= '0;
      r_intstat  <= '0;
      r_intovf   <= '0;
    end else begin
      r_src_prev <= bus.irq_src;
      r_intstat  <= w_stat_next;
      r_intovf   <= w_ovf_next;
    end
  end

  assign w_pend = r_intstat & bus.irq_mask;

  generate
    if (NUM_SRC == 1) begin : g_id_single
      assign w_id = '0;
    end else begin : g_id_enc
      always_comb begin
        w_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (w_pend[i]) w_id = ID_W'(i);
        end
      end
    end
  endgenerate

`ifdef AI_I2S_IRQ_COALESCE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FIRE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_ev_cnt;
  logic [CNT_W-1:0] w_ev_cnt_next;
  logic [CNT_W-1:0] r_tmr;
  logic [CNT_W-1:0] w_tmr_next;
  logic [CNT_W:0]   w_ev_total;
  logic             w_new_set;

  assign w_new_set  = |(w_set & bus.irq_mask);
  // The pending event that opened the window counts as the first one.
  assign w_ev_total = {1'b0, r_ev_cnt} + (CNT_W+1)'(1);

  always_comb begin
    w_state_next  = r_state;
    w_ev_cnt_next = r_ev_cnt;
    w_tmr_next    = r_tmr;
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_state_next  = ST_ACCUM;
          w_ev_cnt_next = '0;
          w_tmr_next    = '0;
        end
      end
      ST_ACCUM: begin
        w_tmr_next = (&r_tmr) ? r_tmr : r_tmr + CNT_W'(1);
        if (w_new_set && !(&r_ev_cnt)) w_ev_cnt_next = r_ev_cnt + CNT_W'(1);
        if (~|w_pend) begin
          w_state_next = ST_IDLE;
        end else if ((w_ev_total >= {1'b0, bus.coal_thresh}) ||
                     ((bus.coal_timeout != '0) && (r_tmr >= bus.coal_timeout))) begin
          w_state_next = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (~|w_pend) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (!bus.irq_en) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ev_cnt <= '0;
      r_tmr    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ev_cnt <= w_ev_cnt_next;
      r_tmr    <= w_tmr_next;
    end
  end

  assign bus.irq_o = (r_state == ST_FIRE);
`else
  logic r_irq;
  logic w_unused_coal;

  assign w_unused_coal = ^{bus.coal_thresh, bus.coal_timeout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= bus.irq_en & (|w_pend);
  end

  assign bus.irq_o = r_irq;
`endif

  assign bus.intstat = r_intstat;
  assign bus.intovf  = r_intovf;
  assign bus.intpend = w_pend;
  assign bus.irq_id  = w_id;

endmodule

// File: tb/tb_ai_i2s_irq_agg.sv
// Scoreboard bench for ai_i2s_irq_agg: directed scenarios plus random traffic,
// expected outputs come from a per-cycle rule model and are checked by a separate monitor.
module tb_ai_i2s_irq_agg;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] stat;
    logic [N-1:0] ovf;
    logic [N-1:0] pend;
    logic         irq;
    logic [1:0]   id;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  exp_t exp_q[$];
  exp_t mon_e;

  logic         t_en;
  logic [N-1:0] t_mask;
  logic [N-1:0] t_mode;

  logic [N-1:0] m_prev;
  logic [N-1:0] m_stat;
  logic [N-1:0] m_ovf;
  logic         m_irq;

  ai_i2s_irq_agg_if #(.NUM_SRC(N), .ID_W(2), .CNT_W(8)) bus_if ();

  ai_i2s_irq_agg #(.NUM_SRC(N), .ID_W(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock of stimulus: apply inputs at negedge, advance the model, queue expectations.
  task automatic step(input logic [N-1:0] src, input logic [N-1:0] clr, input logic [N-1:0] set);
    exp_t         e;
    logic [N-1:0] nst;
    logic [N-1:0] nov;
    logic         rise;
    logic         setb;
    @(negedge clk);
    rst_n            = 1'b1;
    bus_if.irq_en    = t_en;
    bus_if.irq_mask  = t_mask;
    bus_if.irq_mode  = t_mode;
    bus_if.irq_src   = src;
    bus_if.intclr    = clr;
    bus_if.intset    = set;
    for (int i = 0; i < N; i++) begin
      rise = src[i] && !m_prev[i];
      setb = rise || set[i];
      if (t_mode[i]) begin
        nst[i] = src[i] || set[i] || (m_stat[i] && !clr[i]);
        nov[i] = clr[i] ? 1'b0 : m_ovf[i];
      end else begin
        if (setb)        nst[i] = 1'b1;
        else if (clr[i]) nst[i] = 1'b0;
        else             nst[i] = m_stat[i];
        if (m_stat[i] && setb && !clr[i]) nov[i] = 1'b1;
        else if (clr[i])                  nov[i] = 1'b0;
        else                              nov[i] = m_ovf[i];
      end
    end
    m_irq  = t_en && ((m_stat & t_mask) != 0);
    m_stat = nst;
    m_ovf  = nov;
    m_prev = src;
    e.stat = m_stat;
    e.ovf  = m_ovf;
    e.pend = m_stat & t_mask;
    e.irq  = m_irq;
    e.id   = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (e.pend[i]) e.id = 2'(i);
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_intstat", 32'(bus_if.intstat), 32'h0);
    chk("rst_intovf",  32'(bus_if.intovf),  32'h0);
    chk("rst_intpend", 32'(bus_if.intpend), 32'h0);
    chk("rst_irq_o",   32'(bus_if.irq_o),   32'h0);
    chk("rst_irq_id",  32'(bus_if.irq_id),  32'h0);
    exp_q.delete();
    m_prev = '0;
    m_stat = '0;
    m_ovf  = '0;
    m_irq  = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (bus_if.intstat !== mon_e.stat || bus_if.intovf !== mon_e.ovf ||
          bus_if.intpend !== mon_e.pend || bus_if.irq_o !== mon_e.irq ||
          bus_if.irq_id !== mon_e.id) begin
        fails++;
        $display("FAIL scoreboard @%0t: got stat=%b ovf=%b pend=%b irq=%b id=%0d, expected stat=%b ovf=%b pend=%b irq=%b id=%0d",
                 $time, bus_if.intstat, bus_if.intovf, bus_if.intpend, bus_if.irq_o, bus_if.irq_id,
                 mon_e.stat, mon_e.ovf, mon_e.pend, mon_e.irq, mon_e.id);
      end
    end
  end

  initial begin
    logic [N-1:0] r_src;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    t_en = 1'b1; t_mask = '1; t_mode = '0;
    bus_if.irq_en = 1'b0; bus_if.irq_mask = '0; bus_if.irq_mode = '0;
    bus_if.irq_src = '0; bus_if.intclr = '0; bus_if.intset = '0;
    bus_if.coal_thresh = 8'd3; bus_if.coal_timeout = 8'd50;
    m_prev = '0; m_stat = '0; m_ovf = '0; m_irq = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_intstat", 32'(bus_if.intstat), 32'h0);
    chk("init_intovf",  32'(bus_if.intovf),  32'h0);
    chk("init_irq_o",   32'(bus_if.irq_o),   32'h0);
    chk("init_irq_id",  32'(bus_if.irq_id),  32'h0);

    // Edge capture and two-cycle IRQ latency.
    repeat (2) step('0, '0, '0);
    step(4'b0100, '0, '0);
    step('0, '0, '0);
    chk("edge_intstat", 32'(bus_if.intstat), 32'h4);
    chk("edge_irq_lat1", 32'(bus_if.irq_o), 32'h0);
    step('0, '0, '0);
    chk("edge_irq_o", 32'(bus_if.irq_o), 32'h1);
    chk("edge_irq_id", 32'(bus_if.irq_id), 32'h2);
    repeat (5) step('0, '0, '0);
    step('0, 4'b0100, '0);
    step('0, '0, '0);
    chk("clr_intstat", 32'(bus_if.intstat), 32'h0);
    chk("clr_irq_hold", 32'(bus_if.irq_o), 32'h1);
    step('0, '0, '0);
    chk("clr_irq_o", 32'(bus_if.irq_o), 32'h0);

    // Event beats coincident clear; second event without clear sets overflow.
    step(4'b0010, '0, '0);
    step('0, '0, '0);
    step(4'b0010, 4'b0010, '0);
    step('0, '0, '0);
    chk("evt_wins_stat", 32'(bus_if.intstat), 32'h2);
    chk("evt_wins_ovf", 32'(bus_if.intovf), 32'h0);
    step(4'b0010, '0, '0);
    step('0, '0, '0);
    chk("ovf_set", 32'(bus_if.intovf), 32'h2);
    step('0, 4'b0010, '0);
    step('0, '0, '0);
    chk("ovf_clr_stat", 32'(bus_if.intstat), 32'h0);
    chk("ovf_clr_ovf", 32'(bus_if.intovf), 32'h0);

    // Level mode: clear ignored while source is high.
    t_mode = 4'b0001;
    for (int k = 0; k < 10; k++) step(4'b0001, (k == 3) ? 4'b0001 : 4'b0000, '0);
    chk("level_hold", 32'(bus_if.intstat), 32'h1);
    step('0, 4'b0001, '0);
    step('0, '0, '0);
    chk("level_clr", 32'(bus_if.intstat), 32'h0);
    t_mode = '0;

    // Masking and priority id.
    step('0, '0, 4'b1010);
    t_mask = 4'b1010;
    step('0, '0, '0);
    step('0, '0, '0);
    chk("id_low", 32'(bus_if.irq_id), 32'h1);
    chk("id_low_irq", 32'(bus_if.irq_o), 32'h1);
    t_mask = 4'b1000;
    step('0, '0, '0);
    step('0, '0, '0);
    chk("id_masked", 32'(bus_if.irq_id), 32'h3);
    chk("id_masked_irq", 32'(bus_if.irq_o), 32'h1);
    t_en = 1'b0;
    step('0, '0, '0);
    step('0, '0, '0);
    chk("en_off_irq", 32'(bus_if.irq_o), 32'h0);
    t_en = 1'b1;
    t_mask = 4'b1010;
    step('0, '0, '0);
    step('0, '0, '0);
    t_mask = '0;
    step('0, '0, '0);
    step('0, '0, '0);
    chk("mask_off_irq", 32'(bus_if.irq_o), 32'h0);
    chk("mask_off_stat", 32'(bus_if.intstat), 32'ha);

    // Reset mid-operation with a held-high edge source.
    t_mask = '1;
    step('0, '0, 4'b1111);
    step(4'b0001, '0, '0);
    step(4'b0001, '0, '0);
    do_reset();
    step(4'b0001, '0, '0);
    step(4'b0001, 4'b0001, '0);
    step(4'b0001, '0, '0);
    step(4'b0001, '0, '0);
    chk("held_no_retrig", 32'(bus_if.intstat), 32'h0);
    step('0, '0, '0);
    step(4'b0001, '0, '0);
    step('0, '0, '0);
    chk("retrig_after_low", 32'(bus_if.intstat), 32'h1);

    // Random traffic.
    r_src = '0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 50) == 0)  t_mode = N'($urandom);
      if ((c % 20) == 0)  t_mask = N'($urandom);
      if ((c % 37) == 0)  t_en   = ($urandom_range(0, 7) != 0);
      r_src = r_src ^ N'($urandom & $urandom);
      step(r_src, N'($urandom & $urandom), N'($urandom & $urandom & $urandom));
    end
    step('0, '0, '0);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
